// File: rtl/m6502_alu_seq16.sv
// 16-bit ALU sequencer: runs one operation as two byte-wide passes through an
// external 6502-style 8-bit ALU (low byte, then high byte) and registers the result and flags.
module m6502_alu_seq16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic        ready,
    output logic        done,
    output logic [15:0] result,
    output logic        carry,
    output logic        zero,
    output logic        negative,
    output logic        overflow,
    output logic [7:0]  alu_operation,
    output logic [7:0]  alu_op_a,
    output logic [7:0]  alu_op_b,
    output logic        alu_carry_in,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_INC = 3'd2;
    localparam logic [2:0] OP_DEC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state, state_next;
    logic [2:0]  op_q;
    logic [15:0] a_q, b_q;
    logic        cin_q;
    logic [7:0]  lo_res, hi_res;
    logic        lo_carry, lo_zero, hi_carry, hi_zero;

    logic [15:0] eff_b;
    logic [7:0]  code;
    logic        cin_lo;
    logic        is_arith;
    logic [15:0] full, res_n;
    logic        carry_n, zero_n, neg_n, ovf_n;

    function automatic logic calc_overflow(input logic signed [15:0] x,
                                           input logic signed [15:0] e,
                                           input logic signed [15:0] r);
        return ((x < 0) == (e < 0)) && ((r < 0) != (x < 0));
    endfunction

    // Effective second operand, ALU code and low-byte carry-in per operation
    always_comb begin
        eff_b    = b_q;
        code     = 8'h21;
        cin_lo   = 1'b0;
        is_arith = ~op_q[2];
        case (op_q)
            OP_ADD: cin_lo = cin_q;
            OP_SUB: begin eff_b = ~b_q;    cin_lo = 1'b1; end
            OP_INC: begin eff_b = 16'h0000; cin_lo = 1'b1; end
            OP_DEC: eff_b = 16'hFFFF;
            OP_AND: code = 8'h01;
            OP_OR:  code = 8'h02;
            OP_XOR: code = 8'h03;
            OP_CMP: code = 8'h31;
            default: code = 8'h00;
        endcase
    end

    assign ready = (state == IDLE) && !done;

    always_comb begin
        state_next    = state;
        alu_operation = 8'h00;
        alu_op_a      = 8'h00;
        alu_op_b      = 8'h00;
        alu_carry_in  = 1'b0;
        case (state)
            IDLE: if (start && ready) state_next = LO;
            LO: begin
                state_next    = HI;
                alu_operation = code;
                alu_op_a      = a_q[7:0];
                alu_op_b      = eff_b[7:0];
                alu_carry_in  = cin_lo;
            end
            HI: begin
                state_next    = DONE;
                alu_operation = code;
                alu_op_a      = a_q[15:8];
                alu_op_b      = eff_b[15:8];
                alu_carry_in  = is_arith & lo_carry;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Final result and flags assembled from the two captured byte passes
    always_comb begin
        full    = {hi_res, lo_res};
        res_n   = full;
        carry_n = 1'b0;
        zero_n  = (full == 16'h0000);
        neg_n   = full[15];
        ovf_n   = 1'b0;
        if (op_q == OP_CMP) begin
            res_n  = 16'h0000;
            zero_n = lo_zero & hi_zero;
            neg_n  = 1'b0;
        end else if (is_arith) begin
            carry_n = hi_carry;
            ovf_n   = calc_overflow(a_q, eff_b, full);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            op_q     <= 3'd0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            cin_q    <= 1'b0;
            lo_res   <= 8'h00;
            lo_carry <= 1'b0;
            lo_zero  <= 1'b0;
            hi_res   <= 8'h00;
            hi_carry <= 1'b0;
            hi_zero  <= 1'b0;
            result   <= 16'h0000;
            carry    <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == DONE);
            if (state == IDLE && start && ready) begin
                op_q  <= op;
                a_q   <= a;
                b_q   <= b;
                cin_q <= cin;
            end
            if (state == LO) begin
                lo_res   <= alu_result;
                lo_carry <= alu_carry;
                lo_zero  <= alu_zero;
            end
            if (state == HI) begin
                hi_res   <= alu_result;
                hi_carry <= alu_carry;
                hi_zero  <= alu_zero;
            end
            if (state == DONE) begin
                result   <= res_n;
                carry    <= carry_n;
                zero     <= zero_n;
                negative <= neg_n;
                overflow <= ovf_n;
            end
        end
    end

endmodule

// File: tb/tb_m6502_alu_seq16.sv
// Self-checking bench for m6502_alu_seq16 with a behavioural 8-bit ALU and a
// 16-bit arithmetic reference model.
module tb_m6502_alu_seq16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        cin = 1'b0;
    logic        ready, done;
    logic [15:0] result;
    logic        carry, zero, negative, overflow;
    logic [7:0]  alu_operation, alu_op_a, alu_op_b;
    logic        alu_carry_in;
    logic [7:0]  alu_result;
    logic        alu_carry, alu_zero;

    int checks = 0;
    int failures = 0;

    m6502_alu_seq16 dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .ready(ready), .done(done), .result(result),
        .carry(carry), .zero(zero), .negative(negative), .overflow(overflow),
        .alu_operation(alu_operation), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_carry_in(alu_carry_in), .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // 6502-style 8-bit ALU
    logic [8:0] sum9;
    always_comb begin
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        sum9       = 9'd0;
        case (alu_operation)
            8'h21: begin
                sum9       = {1'b0, alu_op_a} + {1'b0, alu_op_b} + {8'd0, alu_carry_in};
                alu_result = sum9[7:0];
                alu_carry  = sum9[8];
            end
            8'h31: begin
                alu_result = alu_op_a - alu_op_b;
                alu_carry  = (alu_op_a >= alu_op_b);
            end
            8'h01: alu_result = alu_op_a & alu_op_b;
            8'h02: alu_result = alu_op_a | alu_op_b;
            8'h03: alu_result = alu_op_a ^ alu_op_b;
            default: alu_result = 8'h00;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: flags packed as {carry, zero, negative, overflow}
    function automatic void model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                                  input logic c, output logic [15:0] r, output logic [3:0] f);
        int sx, sy, s;
        logic [16:0] wide;
        logic cy, v, z, n;
        sx = int'($signed(x));
        sy = int'($signed(y));
        cy = 1'b0; v = 1'b0; r = 16'h0000;
        case (o)
            3'd0: begin
                wide = {1'b0, x} + {1'b0, y} + {16'd0, c};
                r = wide[15:0]; cy = wide[16];
                s = sx + sy + int'(c); v = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                r = x - y; cy = (x >= y);
                s = sx - sy; v = (s > 32767) || (s < -32768);
            end
            3'd2: begin r = x + 16'd1; cy = (x == 16'hFFFF); v = (sx == 32767); end
            3'd3: begin r = x - 16'd1; cy = (x != 16'h0000); v = (sx == -32768); end
            3'd4: r = x & y;
            3'd5: r = x | y;
            3'd6: r = x ^ y;
            default: r = 16'h0000;
        endcase
        z = (r == 16'h0000);
        n = r[15];
        if (o == 3'd7) begin z = (x == y); n = 1'b0; end
        f = {cy, z, n, v};
    endfunction

    function automatic logic [7:0] code_of(input logic [2:0] o);
        case (o)
            3'd4: return 8'h01;
            3'd5: return 8'h02;
            3'd6: return 8'h03;
            3'd7: return 8'h31;
            default: return 8'h21;
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 20) begin @(negedge clk); n++; end
        chk("wait_ready", ready, 1);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                          input logic c, input logic poke);
        logic [15:0] er;
        logic [3:0]  ef;
        int lat;
        model(o, x, y, c, er, ef);
        wait_ready();
        op = o; a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op = 3'($urandom); cin = 1'($urandom);
        @(negedge clk);
        chk("lo_code", alu_operation, code_of(o));
        chk("busy_ready", ready, 0);
        if (poke) start = 1'b1;
        lat = 1;
        while (!done && lat < 10) begin @(negedge clk); lat++; end
        start = 1'b0;
        chk("latency", lat, 4);
        chk("result", result, er);
        chk("flags", {carry, zero, negative, overflow}, ef);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("ready_after", ready, 1);
        if (poke) begin
            @(negedge clk);
            chk("busy_start_ignored", ready, 1);
        end
    endtask

    initial begin
        int dn;
        int idx[$];
        logic [15:0] ra, rb;
        logic [2:0]  ro;

        #3;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_result", result, 16'h0000);
        chk("rst_flags", {carry, zero, negative, overflow}, 4'b0000);
        chk("rst_alu", {alu_operation, alu_op_a, alu_op_b, 7'd0, alu_carry_in}, 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'd0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        chk("add_const", {result, carry, zero, overflow}, {16'h0100, 3'b000});
        run_op(3'd1, 16'h8000, 16'h0001, 1'b0, 1'b0);
        chk("sub_const", {result, carry, overflow, negative}, {16'h7FFF, 3'b110});
        run_op(3'd2, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0);
        chk("inc_const", {result, carry, zero}, {16'h0000, 2'b11});
        run_op(3'd3, 16'h0000, 16'h1234, 1'b1, 1'b0);
        chk("dec_const", {result, carry, negative}, {16'hFFFF, 2'b01});
        run_op(3'd7, 16'h1234, 16'h1234, 1'b0, 1'b0);
        chk("cmp_eq", {result, zero}, {16'h0000, 1'b1});
        run_op(3'd7, 16'h1234, 16'h1235, 1'b0, 1'b0);
        chk("cmp_ne", {result, zero}, {16'h0000, 1'b0});
        run_op(3'd0, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
        run_op(3'd6, 16'hA5A5, 16'h0F0F, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("result_hold", result, 16'hAAAA);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = (i % 5 == 0) ? 16'h8000 : 16'($urandom);
            rb = (i % 7 == 0) ? ra : 16'($urandom);
            run_op(ro, ra, rb, 1'($urandom), 1'(i % 4 == 0));
        end

        // Start held high: ops every 5 cycles
        wait_ready();
        op = 3'd0; a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done) idx.push_back(i);
        end
        start = 1'b0;
        dn = idx.size();
        chk("held_count", dn, 3);
        if (dn == 3) begin
            chk("held_first", idx[0], 3);
            chk("held_gap1", idx[1] - idx[0], 5);
            chk("held_gap2", idx[2] - idx[1], 5);
        end
        chk("held_result", result, 16'h0003);

        // Asynchronous reset while in HI
        run_op(3'd5, 16'h1200, 16'h0034, 1'b0, 1'b0);
        wait_ready();
        op = 3'd0; a = 16'h1234; b = 16'h1111; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_result", result, 16'h0000);
        chk("arst_ready", ready, 1);
        chk("arst_done", done, 0);
        chk("arst_alu", {alu_operation, alu_op_a, alu_op_b, 7'd0, alu_carry_in}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        @(negedge clk);
        chk("arst_ready_after", ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("arst_no_done", dn, 0);
        chk("arst_result_after", result, 16'h0000);

        run_op(3'd1, 16'h0005, 16'h0007, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
